// File: rtl/adc_spi_master.sv
// SPI initiator for the 8-channel 12-bit serial ADC: one 16-SCLK frame per start request,
// returning the 12-bit result tagged with the channel addressed in the previous frame.
module adc_spi_master #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_channel,
  output logic        ADC_SCLK,
  output logic        ADC_CS_N,
  output logic        ADC_SADDR,
  input  logic        ADC_SDAT
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("adc_spi_master: CLK_DIV must be in 2..255");
  end

  localparam logic [7:0] CNT_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [2:0]  cur_ch_q;
  logic [2:0]  prev_ch_q;
  logic [11:0] shift_q;
  logic        busy_q;
  logic        valid_q;
  logic [11:0] data_q;
  logic [2:0]  sch_q;
  logic        sclk_q;
  logic        cs_n_q;
  logic        saddr_q;

  logic        tc;
  logic [11:0] shift_d;
  logic [3:0]  bit_d;
  logic        saddr_d;

  // Address bits go out MSB first on frame bits 2..4; everything else is zero.
  function automatic logic addr_bit(input logic [3:0] b, input logic [2:0] ch);
    case (b)
      4'd2:    addr_bit = ch[2];
      4'd3:    addr_bit = ch[1];
      4'd4:    addr_bit = ch[0];
      default: addr_bit = 1'b0;
    endcase
  endfunction

  // Only 12 bits are kept: the four leading zeros shift out the top by frame end.
  always_comb begin
    tc      = (cnt_q == 8'd0);
    shift_d = {shift_q[10:0], ADC_SDAT};
    bit_d   = bit_q + 4'd1;
    saddr_d = addr_bit(bit_d, cur_ch_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      bit_q     <= 4'd0;
      cur_ch_q  <= 3'd0;
      prev_ch_q <= 3'd0;
      shift_q   <= 12'd0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= 12'd0;
      sch_q     <= 3'd0;
      sclk_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      saddr_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= tc ? CNT_RELOAD : cnt_q - 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SETUP;
            cnt_q    <= CNT_RELOAD;
            bit_q    <= 4'd0;
            cur_ch_q <= channel;
            busy_q   <= 1'b1;
            cs_n_q   <= 1'b0;
            sclk_q   <= 1'b1;
          end
        end
        SETUP: begin
          if (tc) begin
            state_q <= LOW;
            sclk_q  <= 1'b0;
            saddr_q <= addr_bit(4'd0, cur_ch_q);
          end
        end
        LOW: begin
          // Capture on the same edge that raises SCLK; DOUT has been stable since the fall.
          if (tc) begin
            state_q <= HIGH;
            sclk_q  <= 1'b1;
            shift_q <= shift_d;
          end
        end
        HIGH: begin
          if (tc) begin
            if (bit_q == 4'd15) begin
              state_q <= HOLD;
              saddr_q <= 1'b0;
            end else begin
              state_q <= LOW;
              bit_q   <= bit_d;
              sclk_q  <= 1'b0;
              saddr_q <= saddr_d;
            end
          end
        end
        HOLD: begin
          if (tc) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            data_q    <= shift_q;
            sch_q     <= prev_ch_q;
            prev_ch_q <= cur_ch_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign sample_valid   = valid_q;
  assign sample_data    = data_q;
  assign sample_channel = sch_q;
  assign ADC_SCLK       = sclk_q;
  assign ADC_CS_N       = cs_n_q;
  assign ADC_SADDR      = saddr_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: serial ADC model plus a scoreboard of expected samples, where
// each expected sample is the ADC word's low 12 bits tagged with the previous frame's channel.
module tb_adc_spi_master;
  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  channel = 3'd0;
  logic        ADC_SDAT = 1'b0;
  logic        busy;
  logic        sample_valid;
  logic [11:0] sample_data;
  logic [2:0]  sample_channel;
  logic        ADC_SCLK;
  logic        ADC_CS_N;
  logic        ADC_SADDR;

  adc_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .channel(channel),
    .busy(busy), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_channel(sample_channel), .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N),
    .ADC_SADDR(ADC_SADDR), .ADC_SDAT(ADC_SDAT)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] exp_q[$];   // {channel tag, data}
  logic [15:0] word_q[$];
  logic [2:0]  addr_q[$];
  logic [2:0]  prev_ch_m = 3'd0;
  bit          abort_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [2:0] ch, input logic [15:0] w);
    word_q.push_back(w);
    addr_q.push_back(ch);
    exp_q.push_back({prev_ch_m, w[11:0]});
    prev_ch_m = ch;
    channel   = ch;
    start     = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 400);
    chk("valid_seen", sample_valid, 1);
  endtask

  // Output monitor
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", sample_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sample_data", sample_data, e[11:0]);
          chk("sample_channel", sample_channel, e[14:12]);
        end
      end
    end
  end

  // ADC model: DOUT changes after each SCLK fall, DIN sampled at each SCLK rise
  logic        cs_p = 1'b1, sclk_p = 1'b1;
  logic [15:0] adc_w = 16'd0;
  logic [2:0]  adc_a = 3'd0, adc_exp_ch = 3'd0;
  int          adc_k = 0, adc_pulses = 0, adc_lowc = 0, adc_rises = 0;
  bit          adc_stray = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cs_p && !ADC_CS_N) begin
        if (word_q.size() > 0) adc_w = word_q.pop_front();
        else chk("adc_word_available", word_q.size(), 1);
        adc_k = 0; adc_pulses = 0; adc_lowc = 0; adc_rises = 0;
        adc_a = 3'd0; adc_stray = 1'b0;
      end
      if (!ADC_CS_N) begin
        adc_lowc++;
        if (sclk_p && !ADC_SCLK) begin
          if (adc_k < 16) ADC_SDAT = adc_w[15 - adc_k];
          adc_k++;
          adc_pulses++;
        end
        if (!sclk_p && ADC_SCLK) begin
          if (adc_rises >= 2 && adc_rises <= 4) adc_a[4 - adc_rises] = ADC_SADDR;
          else if (ADC_SADDR !== 1'b0) adc_stray = 1'b1;
          adc_rises++;
        end
      end
      if (!cs_p && ADC_CS_N) begin
        if (addr_q.size() > 0) adc_exp_ch = addr_q.pop_front();
        else chk("adc_addr_available", addr_q.size(), 1);
        if (abort_pending) begin
          abort_pending = 1'b0;
        end else begin
          chk("sclk_pulses", adc_pulses, 16);
          chk("cs_low_cycles", adc_lowc, 34 * CLK_DIV);
          chk("saddr_channel", adc_a, adc_exp_ch);
          chk("saddr_other_bits_zero", adc_stray, 0);
        end
        ADC_SDAT = 1'b0;
      end
      cs_p   = ADC_CS_N;
      sclk_p = ADC_SCLK;
    end
  end

  // Stimulus
  initial begin
    int n;
    bit ok;
    logic [2:0] chs [3];
    chs[0] = 3'd3; chs[1] = 3'd6; chs[2] = 3'd1;

    // Reset and idle quiet
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", ADC_CS_N, 1);
    chk("rst_sclk", ADC_SCLK, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_data", sample_data, 0);
    chk("reset_channel", sample_channel, 0);
    chk("reset_saddr", ADC_SADDR, 0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ADC_SCLK !== 1'b1 || ADC_CS_N !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("idle_quiet", ok, 1);

    // Single frame, channel 5, known word, latency check
    issue(3'd5, 16'h0A5C);
    @(negedge clk);
    start = 1'b0;
    chk("cs_fall_T+1", ADC_CS_N, 0);
    chk("busy_T+1", busy, 1);
    wait_valid(n);
    chk("valid_latency", n + 1, 34 * CLK_DIV + 1);
    chk("cs_high_at_valid", ADC_CS_N, 1);
    chk("busy_low_at_valid", busy, 0);

    // Back-to-back frames with start held high, channel changed mid-frame
    repeat (3) @(negedge clk);
    issue(chs[0], 16'($urandom));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (k < 2) issue(chs[k + 1], 16'($urandom));
      else start = 1'b0;
      wait_valid(n);
      chk("b2b_cs_high_at_valid", ADC_CS_N, 1);
      if (k < 2) begin
        @(negedge clk);
        chk("b2b_cs_low_next", ADC_CS_N, 0);
      end
    end

    // Start pulse mid-frame is ignored
    repeat (4) @(negedge clk);
    issue(3'd4, 16'($urandom));
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1;
    channel = 3'd2;
    repeat (4) @(negedge clk);
    start = 1'b0;
    channel = 3'($urandom);
    wait_valid(n);
    ok = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (ADC_CS_N !== 1'b1) ok = 1'b0;
    end
    chk("no_queued_frame", ok, 1);

    // Reset mid-frame
    issue(3'd7, 16'($urandom));
    @(negedge clk);
    start = 1'b0;
    repeat (37) @(negedge clk);
    abort_pending = 1'b1;
    void'(exp_q.pop_back());
    prev_ch_m = 3'd0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", ADC_CS_N, 1);
    chk("abort_sclk", ADC_SCLK, 1);
    chk("abort_busy", busy, 0);
    chk("abort_valid", sample_valid, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    issue(3'd1, 16'($urandom));
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);

    // Leading bits ignored
    repeat (2) @(negedge clk);
    issue(3'd2, 16'hF000);
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);
    issue(3'd6, 16'h0FFF);
    @(negedge clk);
    start = 1'b0;
    wait_valid(n);

    // Random frames with random gaps (gap 0 gives back-to-back acceptance)
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      issue(3'($urandom), 16'($urandom));
      @(negedge clk);
      start = 1'b0;
      wait_valid(n);
    end

    repeat (10) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("word_queue_drained", word_q.size(), 0);
    chk("addr_queue_drained", addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
